// File: rtl/bp_table_scheduler_if.sv
// Lookup / update handshake bundle between the branch predictor front end and
// the PHT scheduler.
//   master : fetch/resolve side (drives requests, receives ready/prediction)
//   slave  : scheduler side
// Signals:
//   lk_valid, lk_pc         lookup request and branch address
//   lk_ready                lookup accepted this cycle
//   pred_valid, pred_taken  one-cycle prediction result
//   up_valid, up_pc         resolved-branch update request and address
//   up_taken, up_mispredict actual outcome and misprediction flag
//   up_ready                update FIFO can accept
interface bp_table_scheduler_if #(
   parameter int Direction_SIZE = 32
);
   logic                      lk_valid;
   logic [Direction_SIZE-1:0] lk_pc;
   logic                      lk_ready;
   logic                      pred_valid;
   logic                      pred_taken;
   logic                      up_valid;
   logic [Direction_SIZE-1:0] up_pc;
   logic                      up_taken;
   logic                      up_mispredict;
   logic                      up_ready;

   modport master (
      output lk_valid, lk_pc, up_valid, up_pc, up_taken, up_mispredict,
      input  lk_ready, pred_valid, pred_taken, up_ready
   );

   modport slave (
      input  lk_valid, lk_pc, up_valid, up_pc, up_taken, up_mispredict,
      output lk_ready, pred_valid, pred_taken, up_ready
   );
endinterface

// File: rtl/bp_table_scheduler.sv
// Sequencer/arbiter for a single-ported 2-bit-counter pattern history table.
// Shares the table between the lookup port and a FIFO of resolved-branch
// updates (applied as read-modify-write), initialises every entry to weakly
// not-taken after reset and keeps lookup/update/mispredict statistics.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   bp (slave)         lookup / prediction / update handshake bundle
//   tbl_en, tbl_we     table access and write enables
//   tbl_index          table index (0 when tbl_en is low)
//   tbl_wdata          table write data (0 when tbl_en is low)
//   tbl_rdata          table read data, valid the cycle after a read
//   init_done          initialisation sweep finished
//   lookup_count       accepted lookups
//   update_count       applied updates
//   mispredict_count   applied updates flagged as mispredicted
module bp_table_scheduler #(
   parameter int Direction_SIZE = 32,
   parameter int INDEX_BITS     = 7,
   parameter int UQ_DEPTH       = 4,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   bp_table_scheduler_if.slave   bp,
   output logic                  tbl_en,
   output logic                  tbl_we,
   output logic [INDEX_BITS-1:0] tbl_index,
   output logic [1:0]            tbl_wdata,
   input  logic [1:0]            tbl_rdata,
   output logic                  init_done,
   output logic [31:0]           lookup_count,
   output logic [31:0]           update_count,
   output logic [31:0]           mispredict_count
);
   localparam int PW = $clog2(UQ_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]         FULL_CNT   = CW'(UQ_DEPTH);
   localparam logic [SW-1:0]         STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [INDEX_BITS-1:0] LAST_IDX   = {INDEX_BITS{1'b1}};
   localparam logic [1:0]            CNT_WN     = 2'b01;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_IDLE     = 2'd1,
      ST_LK_RESP  = 2'd2,
      ST_UP_WRITE = 2'd3
   } state_t;

   // Saturating 2-bit counter step toward the resolved outcome.
   function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
      end else begin
         res = (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
      end
      return res;
   endfunction

   state_t                state_r;
   logic [INDEX_BITS-1:0] init_ptr_r;
   logic                  init_done_r;
   logic [SW-1:0]         starve_r;
   logic [31:0]           lookup_count_r;
   logic [31:0]           update_count_r;
   logic [31:0]           mispredict_count_r;

   logic [INDEX_BITS-1:0] q_idx_r [UQ_DEPTH];
   logic [UQ_DEPTH-1:0]   q_taken_r;
   logic [UQ_DEPTH-1:0]   q_misp_r;
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;

   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  lk_grant_s;
   logic                  up_grant_s;
   logic [INDEX_BITS-1:0] lk_idx_s;
   logic [INDEX_BITS-1:0] up_idx_s;
   logic [INDEX_BITS-1:0] head_idx_s;
   logic                  head_taken_s;
   logic                  head_misp_s;
   logic                  up_ready_s;
   logic                  unused_s;

   assign lk_idx_s     = bp.lk_pc[INDEX_BITS+1:2];
   assign up_idx_s     = bp.up_pc[INDEX_BITS+1:2];
   assign unused_s     = ^{bp.lk_pc[Direction_SIZE-1:INDEX_BITS+2], bp.lk_pc[1:0],
                           bp.up_pc[Direction_SIZE-1:INDEX_BITS+2], bp.up_pc[1:0]};
   assign head_idx_s   = q_idx_r[rd_ptr_r];
   assign head_taken_s = q_taken_r[rd_ptr_r];
   assign head_misp_s  = q_misp_r[rd_ptr_r];
   assign fifo_full_s  = (count_r == FULL_CNT);
   assign fifo_empty_s = (count_r == {CW{1'b0}});
   // up_ready reflects pre-pop occupancy, so a pop in UP_WRITE does not
   // re-open the port in the same cycle.
   assign up_ready_s   = init_done_r && !fifo_full_s;
   assign push_s       = bp.up_valid && up_ready_s;
   assign pop_s        = (state_r == ST_UP_WRITE);

   // Arbitration between queued updates and the lookup port in IDLE.
   always_comb begin
      lk_grant_s = 1'b0;
      up_grant_s = 1'b0;
      if (state_r == ST_IDLE) begin
         if (fifo_full_s) begin
            up_grant_s = 1'b1;
         end else if (!fifo_empty_s && (starve_r == STARVE_MAX)) begin
            up_grant_s = 1'b1;
         end else if (bp.lk_valid) begin
            lk_grant_s = 1'b1;
         end else if (!fifo_empty_s) begin
            up_grant_s = 1'b1;
         end else begin
            up_grant_s = 1'b0;
         end
      end else begin
         lk_grant_s = 1'b0;
      end
   end

   // Table port drive; everything is forced low while reset is asserted.
   always_comb begin
      tbl_en    = 1'b0;
      tbl_we    = 1'b0;
      tbl_index = {INDEX_BITS{1'b0}};
      tbl_wdata = 2'b00;
      if (reset) begin
         tbl_en = 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               tbl_en    = 1'b1;
               tbl_we    = 1'b1;
               tbl_index = init_ptr_r;
               tbl_wdata = CNT_WN;
            end
            ST_IDLE: begin
               if (lk_grant_s) begin
                  tbl_en    = 1'b1;
                  tbl_index = lk_idx_s;
               end else if (up_grant_s) begin
                  tbl_en    = 1'b1;
                  tbl_index = head_idx_s;
               end else begin
                  tbl_en = 1'b0;
               end
            end
            ST_LK_RESP: tbl_en = 1'b0;
            ST_UP_WRITE: begin
               tbl_en    = 1'b1;
               tbl_we    = 1'b1;
               tbl_index = head_idx_s;
               tbl_wdata = sat_next(tbl_rdata, head_taken_s);
            end
            default: tbl_en = 1'b0;
         endcase
      end
   end

   assign bp.lk_ready   = !reset && lk_grant_s;
   assign bp.pred_valid = !reset && (state_r == ST_LK_RESP);
   assign bp.pred_taken = !reset && (state_r == ST_LK_RESP) && tbl_rdata[1];
   assign bp.up_ready   = !reset && up_ready_s;
   assign init_done        = !reset && init_done_r;
   assign lookup_count     = reset ? 32'd0 : lookup_count_r;
   assign update_count     = reset ? 32'd0 : update_count_r;
   assign mispredict_count = reset ? 32'd0 : mispredict_count_r;

   // Sequencer, init sweep, starvation tracking and statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r            <= ST_INIT;
         init_ptr_r         <= {INDEX_BITS{1'b0}};
         init_done_r        <= 1'b0;
         starve_r           <= {SW{1'b0}};
         lookup_count_r     <= 32'd0;
         update_count_r     <= 32'd0;
         mispredict_count_r <= 32'd0;
      end else begin
         case (state_r)
            ST_INIT: begin
               init_ptr_r <= init_ptr_r + INDEX_BITS'(1);
               if (init_ptr_r == LAST_IDX) begin
                  init_done_r <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (lk_grant_s) begin
                  state_r        <= ST_LK_RESP;
                  lookup_count_r <= lookup_count_r + 32'd1;
               end else if (up_grant_s) begin
                  state_r <= ST_UP_WRITE;
               end
            end
            ST_LK_RESP: state_r <= ST_IDLE;
            ST_UP_WRITE: begin
               state_r        <= ST_IDLE;
               update_count_r <= update_count_r + 32'd1;
               if (head_misp_s) begin
                  mispredict_count_r <= mispredict_count_r + 32'd1;
               end
            end
            default: state_r <= ST_INIT;
         endcase
         // Only lookups granted while updates wait count toward starvation.
         if (up_grant_s || fifo_empty_s) begin
            starve_r <= {SW{1'b0}};
         end else if (lk_grant_s && (starve_r != STARVE_MAX)) begin
            starve_r <= starve_r + SW'(1);
         end
      end
   end

   // Update FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Update FIFO payload storage.
   always_ff @(posedge clk) begin
      if (push_s) begin
         q_idx_r[wr_ptr_r]   <= up_idx_s;
         q_taken_r[wr_ptr_r] <= bp.up_taken;
         q_misp_r[wr_ptr_r]  <= bp.up_mispredict;
      end
   end
endmodule

// File: tb/tb_bp_table_scheduler.sv
// Self-checking bench for bp_table_scheduler: models the PHT memory, keeps a
// reference counter table and scoreboards expected writes and predictions.
module tb_bp_table_scheduler;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tbl_en, tbl_we;
   logic [6:0]  tbl_index;
   logic [1:0]  tbl_wdata;
   logic [1:0]  tbl_rdata;
   logic        init_done;
   logic [31:0] lookup_count, update_count, mispredict_count;

   bp_table_scheduler_if #(.Direction_SIZE(32)) bp ();

   bp_table_scheduler #(
      .Direction_SIZE(32), .INDEX_BITS(7), .UQ_DEPTH(4), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .reset(reset), .bp(bp),
      .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_index(tbl_index),
      .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata), .init_done(init_done),
      .lookup_count(lookup_count), .update_count(update_count),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0] mem     [128];
   logic [1:0] ref_pht [128];
   logic [8:0] exp_wr_q [$];
   logic       exp_pred_q [$];
   int exp_lk   = 0;
   int exp_upd  = 0;
   int exp_misp = 0;
   logic [8:0] mon_wr;
   logic       mon_pred;
   logic [6:0] mon_idx;

   // PHT memory with one-cycle read latency.
   always @(posedge clk) begin
      if (tbl_en) begin
         if (tbl_we) mem[tbl_index] <= tbl_wdata;
         else tbl_rdata <= mem[tbl_index];
      end
   end

   // Scoreboard: compare predictions and post-init writes, record lookup grants.
   always @(negedge clk) begin
      if (bp.pred_valid) begin
         n_checks++;
         if (exp_pred_q.size() == 0) begin
            n_fail++;
            $display("FAIL pred_unexpected got=%0b", bp.pred_taken);
         end else begin
            mon_pred = exp_pred_q.pop_front();
            if (bp.pred_taken !== mon_pred) begin
               n_fail++;
               $display("FAIL pred_taken got=%0b exp=%0b", bp.pred_taken, mon_pred);
            end
         end
      end
      if (tbl_en && tbl_we && init_done) begin
         n_checks++;
         if (exp_wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL write_unexpected idx=%0d data=%b", tbl_index, tbl_wdata);
         end else begin
            mon_wr = exp_wr_q.pop_front();
            if ({tbl_index, tbl_wdata} !== mon_wr) begin
               n_fail++;
               $display("FAIL write idx/data got=%0d/%b exp=%0d/%b",
                        tbl_index, tbl_wdata, mon_wr[8:2], mon_wr[1:0]);
            end
         end
      end
      if (bp.lk_valid && bp.lk_ready) begin
         mon_idx = bp.lk_pc[8:2];
         exp_pred_q.push_back(ref_pht[mon_idx][1]);
         exp_lk++;
      end
   end

   function automatic logic [1:0] model_sat(input logic [1:0] c, input bit t);
      int v;
      v = int'(c) + (t ? 1 : -1);
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      return 2'(v);
   endfunction

   task automatic rec_update(input logic [31:0] pc, input bit t, input bit m);
      logic [6:0] idx;
      logic [1:0] nv;
      idx = pc[8:2];
      nv = model_sat(ref_pht[idx], t);
      ref_pht[idx] = nv;
      exp_wr_q.push_back({idx, nv});
      exp_upd++;
      if (m) exp_misp++;
   endtask

   task automatic ref_reset();
      for (int i = 0; i < 128; i++) ref_pht[i] = 2'b01;
      exp_wr_q.delete();
      exp_pred_q.delete();
      exp_lk = 0; exp_upd = 0; exp_misp = 0;
   endtask

   // Single update push (holds up_valid until accepted).
   task automatic push_update(input logic [31:0] pc, input bit t, input bit m);
      int g = 0;
      @(posedge clk); #1;
      bp.up_valid = 1'b1; bp.up_pc = pc; bp.up_taken = t; bp.up_mispredict = m;
      @(negedge clk);
      while (!bp.up_ready && g < 200) begin @(negedge clk); g++; end
      n_checks++;
      if (!bp.up_ready) begin
         n_fail++;
         $display("FAIL push_timeout up_ready=%0b exp=1", bp.up_ready);
      end else rec_update(pc, t, m);
      @(posedge clk); #1;
      bp.up_valid = 1'b0;
   endtask

   // Back-to-back pushes; called in the posedge+1 phase, returns in it.
   task automatic push_burst(input int n, input logic [31:0] pc, input bit t, input bit m);
      int pushed = 0;
      int g = 0;
      bp.up_valid = 1'b1; bp.up_pc = pc; bp.up_taken = t; bp.up_mispredict = m;
      while (pushed < n && g < 100) begin
         @(negedge clk);
         if (bp.up_ready) begin rec_update(pc, t, m); pushed++; end
         g++;
         @(posedge clk); #1;
      end
      bp.up_valid = 1'b0;
      n_checks++;
      if (pushed != n) begin
         n_fail++;
         $display("FAIL burst_pushed got=%0d exp=%0d", pushed, n);
      end
   endtask

   task automatic do_lookup(input logic [31:0] pc);
      int g = 0;
      @(posedge clk); #1;
      bp.lk_valid = 1'b1; bp.lk_pc = pc;
      @(negedge clk);
      while (!bp.lk_ready && g < 50) begin @(negedge clk); g++; end
      n_checks++;
      if (!(bp.lk_ready && tbl_en && !tbl_we && tbl_index == pc[8:2])) begin
         n_fail++;
         $display("FAIL lookup_grant rdy/en/we/idx got=%0b/%0b/%0b/%0d exp=1/1/0/%0d",
                  bp.lk_ready, tbl_en, tbl_we, tbl_index, pc[8:2]);
      end
      @(posedge clk); #1;
      bp.lk_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bp.pred_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL pred_latency pred_valid got=%0b exp=1", bp.pred_valid);
      end
      n_checks++;
      if (lookup_count !== 32'(exp_lk)) begin
         n_fail++;
         $display("FAIL lookup_count got=%0d exp=%0d", lookup_count, exp_lk);
      end
   endtask

   task automatic wait_drain();
      int g = 0;
      @(negedge clk);
      while ((update_count != 32'(exp_upd) || exp_wr_q.size() != 0) && g < 300) begin
         @(negedge clk); g++;
      end
      n_checks++;
      if (update_count !== 32'(exp_upd) || exp_wr_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain update_count got=%0d exp=%0d pending=%0d",
                  update_count, exp_upd, exp_wr_q.size());
      end
      n_checks++;
      if (mispredict_count !== 32'(exp_misp)) begin
         n_fail++;
         $display("FAIL mispredict_count got=%0d exp=%0d", mispredict_count, exp_misp);
      end
   endtask

   task automatic check_init_sweep(input string tag);
      int bad = 0;
      int g = 0;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         if (!(tbl_en && tbl_we && tbl_index == 7'(i) && tbl_wdata == 2'b01 && !init_done)) begin
            if (bad == 0)
               $display("FAIL %s_sweep i=%0d got en/we/idx/data/done=%0b/%0b/%0d/%b/%0b exp=1/1/%0d/01/0",
                        tag, i, tbl_en, tbl_we, tbl_index, tbl_wdata, init_done, i);
            bad++;
         end
      end
      n_checks++;
      if (bad != 0) n_fail++;
      @(negedge clk);
      n_checks++;
      if (!(init_done && !tbl_we && bp.up_ready)) begin
         n_fail++;
         $display("FAIL %s_done init_done/we/up_ready got=%0b/%0b/%0b exp=1/0/1",
                  tag, init_done, tbl_we, bp.up_ready);
      end
      n_checks++;
      if ({lookup_count, update_count, mispredict_count} !== 96'd0) begin
         n_fail++;
         $display("FAIL %s_counters got=%0d/%0d/%0d exp=0/0/0",
                  tag, lookup_count, update_count, mispredict_count);
      end
      g = g;
   endtask

   task automatic test_reset();
      ref_reset();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if ({tbl_en, tbl_we, tbl_index, tbl_wdata, init_done, bp.lk_ready,
              bp.pred_valid, bp.up_ready} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs en/we/idx/done/upr got=%0b/%0b/%0d/%0b/%0b exp=0",
                     tbl_en, tbl_we, tbl_index, init_done, bp.up_ready);
         end
      end
      @(posedge clk); #1;
      reset = 1'b0;
      check_init_sweep("reset");
   endtask

   task automatic test_single_lookup();
      do_lookup(32'h0000_0010);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) push_update(32'h0000_0010, 1'b1, 1'b0);
      wait_drain();
      do_lookup(32'h0000_0010);
      for (int i = 0; i < 4; i++) push_update(32'h0000_0010, 1'b0, 1'b0);
      wait_drain();
      do_lookup(32'h0000_0010);
   endtask

   task automatic test_fifo_full();
      int g = 0;
      bit found = 1'b0;
      @(posedge clk); #1;
      bp.lk_valid = 1'b1; bp.lk_pc = 32'h0000_0100;
      push_burst(4, 32'h0000_0020, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (bp.up_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_up_ready got=%0b exp=0", bp.up_ready);
      end
      while (!found && g < 20) begin
         if (tbl_en && !tbl_we) found = 1'b1;
         else begin @(negedge clk); g++; end
      end
      n_checks++;
      if (!(found && tbl_index == 7'd8 && !bp.lk_ready)) begin
         n_fail++;
         $display("FAIL full_priority found/idx/lk_ready got=%0b/%0d/%0b exp=1/8/0",
                  found, tbl_index, bp.lk_ready);
      end
      @(posedge clk); #1;
      bp.lk_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_starvation();
      @(posedge clk); #1;
      bp.lk_valid = 1'b1; bp.lk_pc = 32'h0000_0100;
      for (int r = 0; r < 2; r++) begin
         int n = 0;
         int g = 0;
         bit hit = 1'b0;
         push_update(32'h0000_0030, 1'b1, (r == 0));
         while (!hit && g < 40) begin
            @(negedge clk); g++;
            if (tbl_en && !tbl_we && tbl_index == 7'd12 && !bp.lk_ready) hit = 1'b1;
            else if (bp.lk_ready) n++;
         end
         n_checks++;
         if (!(hit && n == 4)) begin
            n_fail++;
            $display("FAIL starve_round%0d lookups_before_update got=%0d (granted=%0b) exp=4",
                     r, n, hit);
         end
      end
      @(posedge clk); #1;
      bp.lk_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_reset_mid_update();
      int g = 0;
      bit hit = 1'b0;
      @(posedge clk); #1;
      bp.lk_valid = 1'b1; bp.lk_pc = 32'h0000_0100;
      push_burst(4, 32'h0000_0040, 1'b1, 1'b1);
      while (!hit && g < 20) begin
         @(negedge clk); g++;
         if (tbl_en && !tbl_we && tbl_index == 7'd16 && !bp.lk_ready) hit = 1'b1;
      end
      @(posedge clk); #1;
      reset = 1'b1;
      bp.lk_valid = 1'b0;
      ref_reset();
      @(negedge clk);
      n_checks++;
      if (!(hit && !tbl_en && !tbl_we)) begin
         n_fail++;
         $display("FAIL rst_mid_write hit/en/we got=%0b/%0b/%0b exp=1/0/0", hit, tbl_en, tbl_we);
      end
      @(negedge clk);
      n_checks++;
      if ({update_count, bp.up_ready, init_done, bp.pred_valid} !== 35'd0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs upd/upr/done/pv got=%0d/%0b/%0b/%0b exp=0",
                  update_count, bp.up_ready, init_done, bp.pred_valid);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      check_init_sweep("rst_mid");
      g = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (tbl_en) g++;
      end
      n_checks++;
      if (g != 0) begin
         n_fail++;
         $display("FAIL rst_mid_fifo_flushed accesses got=%0d exp=0", g);
      end
   endtask

   initial begin
      bp.lk_valid = 1'b0; bp.lk_pc = 32'd0;
      bp.up_valid = 1'b0; bp.up_pc = 32'd0; bp.up_taken = 1'b0; bp.up_mispredict = 1'b0;
      test_reset();
      test_single_lookup();
      test_saturation();
      test_fifo_full();
      test_starvation();
      test_reset_mid_update();
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_pred_q.size() != 0) begin
         n_fail++;
         $display("FAIL pred_missing pending=%0d exp=0", exp_pred_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time_limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/bp_table_scheduler.md
# bp_table_scheduler

Sequencer and arbiter for the single-ported 2-bit-counter pattern history table (PHT) behind the branch predictor. It shares the table between the fetch-side lookup port and the resolve-side update port. Updates are buffered in a small FIFO and applied as read-modify-write operations. After every reset the block initialises the table, and it keeps lookup, update and misprediction statistics.

## Interface

Parameters:
- Direction_SIZE, 32: branch address width.
- INDEX_BITS, 7: PHT index width; table depth is 2^INDEX_BITS.
- UQ_DEPTH, 4: update FIFO depth (power of two, at least 2).
- STARVE_LIMIT, 4: consecutive lookup grants allowed while the FIFO is non-empty.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- lk_valid, input, 1: lookup request.
- lk_pc, input, Direction_SIZE: branch address to predict.
- lk_ready, output, 1: lookup accepted this cycle when lk_valid is also high.
- pred_valid, output, 1: one-cycle pulse marking the prediction result.
- pred_taken, output, 1: prediction (counter MSB).
- up_valid, input, 1: resolved-branch update request.
- up_pc, input, Direction_SIZE: resolved branch address.
- up_taken, input, 1: actual outcome.
- up_mispredict, input, 1: the earlier prediction was wrong.
- up_ready, output, 1: FIFO can accept an update.
- tbl_en, output, 1: PHT access enable.
- tbl_we, output, 1: PHT write enable.
- tbl_index, output, INDEX_BITS: PHT index.
- tbl_wdata, output, 2: PHT write data.
- tbl_rdata, input, 2: PHT read data, valid the cycle after a read.
- init_done, output, 1: table initialisation complete.
- lookup_count, output, 32: accepted lookups.
- update_count, output, 32: applied updates.
- mispredict_count, output, 32: applied updates that carried up_mispredict.

## Operation

- Index mapping: index = pc[INDEX_BITS+1:2].
- Counter encoding: 00 SN, 01 WN, 10 WT, 11 ST.
- States:
  - INIT: write 01 to index init_ptr, one entry per cycle. After entry 2^INDEX_BITS-1 is written, set init_done and go to IDLE.
  - IDLE: arbitrate and issue the read for the winner.
  - LK_RESP: drive pred_valid and pred_taken = tbl_rdata[1]; return to IDLE.
  - UP_WRITE: compute the saturating counter from tbl_rdata and write it back; pop the FIFO head; return to IDLE.
- Arbitration in IDLE, in priority order:
  1. FIFO full → update.
  2. FIFO non-empty and starve_cnt == STARVE_LIMIT → update.
  3. lk_valid → lookup.
  4. FIFO non-empty → update.
  5. Otherwise, no access.
- starve_cnt:
  - Increments on each lookup grant while the FIFO is non-empty.
  - Clears on any update grant and whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Ready signals:
  - lk_ready = IDLE && lookup wins arbitration.
  - up_ready = init_done && FIFO not full.
- Simultaneous push and pop in UP_WRITE is allowed. The pop frees the slot on the same edge, but up_ready is still based on the pre-pop occupancy.
- Saturating update: up_taken increments toward 11 (11 stays 11); otherwise decrements toward 00 (00 stays 00).
- Statistics counters:
  - lookup_count increments at lookup grant.
  - update_count and mispredict_count increment in UP_WRITE.
  - All are 32-bit and wrap modulo 2^32.
- No forwarding between accesses. A lookup always sees all writes completed before its read cycle. Updates still queued in the FIFO are not visible to lookups.
- Reset during any state:
  - Returns to INIT with init_ptr = 0.
  - Flushes the FIFO.
  - Clears starve_cnt, all counters and init_done.
  - Discards any in-flight lookup or update; no pred_valid is produced for it.

## Timing

- While reset is high, all outputs are 0 and no table access occurs.
- First cycle after reset is deasserted:
  - tbl_en = tbl_we = 1, tbl_index = 0, tbl_wdata = 01.
  - init_done rises after 2^INDEX_BITS cycles (128 by default).
- Lookup accepted at cycle t:
  - t: tbl_en = 1, tbl_we = 0, tbl_index = lk_pc index.
  - t+1: pred_valid = 1 with pred_taken; lk_ready = 0.
  - t+2: next grant possible. Lookup throughput is one per 2 cycles.
- Update granted at cycle t:
  - t: read issued.
  - t+1: write issued (tbl_we = 1) and FIFO popped.
  - t+2: next grant possible.
- FIFO enqueue latency: an update pushed at cycle t is grantable at t+1 at the earliest.
- Between operations: tbl_en = 0 in an idle cycle with no grant. tbl_index and tbl_wdata are 0 whenever tbl_en = 0.

## Test plan

- Reset then idle: reset high for 2 cycles, then low → tbl_we high for exactly 128 consecutive cycles, indices 0..127 with data 01; init_done rises on cycle 129; all counters read 0.
- Single lookup after init: lk_pc = 0x0000_0010 → tbl_index = 4 at grant; pred_valid pulses next cycle with pred_taken = 0 (WN); lookup_count = 1.
- Saturation: three updates to pc 0x10 with up_taken = 1, then a lookup → writes 10, 11, 11 in sequence; pred_taken = 1. Then four not-taken updates → writes 10, 01, 00, 00.
- FIFO full priority: hold lk_valid high, push 4 updates → up_ready drops after the 4th push; the next IDLE grant goes to an update even though lk_valid is high.
- Starvation: continuous lk_valid with 1 queued update → update granted after exactly 4 lookup grants; starve_cnt clears; mispredict_count increments when up_mispredict = 1.
- Reset mid-update: assert reset in UP_WRITE with 3 entries queued → no write that cycle; FIFO empty; INIT restarts at index 0; update_count = 0.
